// File: rtl/oscillo_pkg.sv
// Shared types and helpers for the acquisition readout path: state encoding,
// channel-selection result and the next-enabled-channel search.
package oscillo_pkg;

  localparam int RAM_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAITQ,
    SEND,
    FIN
  } rd_state_t;

  typedef struct packed {
    logic       none;
    logic [1:0] ch;
  } chan_sel_t;

  // Lowest enabled channel strictly above ch; none=1 when nothing is left.
  function automatic chan_sel_t next_chan(input logic [3:0] mask, input logic [1:0] ch);
    chan_sel_t sel;
    sel.none = 1'b1;
    sel.ch   = ch;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(ch))) begin
        sel.none = 1'b0;
        sel.ch   = 2'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mask_walker.sv
// Holds the channel mask captured at readout start and walks its set bits,
// lowest first.
module mask_walker
  import oscillo_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] mask_in,
  input  logic       advance,
  output logic [1:0] ch,
  output logic       more,
  output logic       empty
);

  logic [3:0] mask_q;
  chan_sel_t  first_sel;
  chan_sel_t  next_sel;
  logic [1:0] first_ch;

  // NOTE: every always_comb output gets an unconditional value first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    first_sel = next_chan(mask_in, 2'd0);
    first_ch  = mask_in[0] ? 2'd0 : first_sel.ch;
    empty     = !mask_in[0] && first_sel.none;
    next_sel  = next_chan(mask_q, ch);
    more      = !next_sel.none;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask_q <= '0;
      ch     <= '0;
    end else if (load) begin
      mask_q <= mask_in;
      ch     <= first_ch;
    end else if (advance && !next_sel.none) begin
      ch <= next_sel.ch;
    end
  end

endmodule

// File: rtl/waveform_readout.sv
// Reads the captured pre/post-trigger window out of the circular sample RAM
// and streams it channel-major as bytes over a valid/ready interface.
module waveform_readout
  import oscillo_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int RAM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] trig_addr,
  input  logic [RAM_WIDTH-1:0] pretrig,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [3:0]           chan_mask,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [31:0]          ram_q,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  rd_state_t            state, state_d;
  logic                 pending, pending_d;
  logic                 busy_d, rden_d, out_valid_d, done_d;
  logic [RAM_WIDTH-1:0] rdaddress_d;
  logic [7:0]           out_data_d;
  logic [RAM_WIDTH-1:0] base, base_d, addr, addr_d, cnt, cnt_d, nsmp_q, nsmp_d;
  logic [1:0]           lat_cnt, lat_d;

  logic [RAM_WIDTH-1:0] base_new, addr_inc;
  logic [RAM_WIDTH:0]   cnt_inc;
  logic                 wk_load, wk_adv, wk_more, wk_empty;
  logic [1:0]           ch;

  mask_walker u_mask_walker (
    .clk     (clk),
    .rstn    (rstn),
    .load    (wk_load),
    .mask_in (chan_mask),
    .advance (wk_adv),
    .ch      (ch),
    .more    (wk_more),
    .empty   (wk_empty)
  );

  // Window start wraps naturally in RAM_WIDTH bits.
  assign base_new = trig_addr - pretrig;
  assign addr_inc = addr + RAM_WIDTH'(1);
  assign cnt_inc  = {1'b0, cnt} + (RAM_WIDTH + 1)'(1);

  always_comb begin
    state_d     = state;
    pending_d   = pending;
    busy_d      = busy;
    rden_d      = 1'b0;
    rdaddress_d = rdaddress;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    base_d      = base;
    addr_d      = addr;
    cnt_d       = cnt;
    nsmp_d      = nsmp_q;
    lat_d       = lat_cnt;
    wk_load     = 1'b0;
    wk_adv      = 1'b0;

    case (state)
      IDLE: begin
        if (start && !busy) begin
          pending_d = 1'b1;
          busy_d    = 1'b1;
        end
        if (pending && data_ready) begin
          pending_d = 1'b0;
          wk_load   = 1'b1;
          nsmp_d    = nsmp;
          base_d    = base_new;
          addr_d    = base_new;
          cnt_d     = '0;
          if (wk_empty || nsmp == '0) begin
            state_d = FIN;
          end else begin
            state_d     = ISSUE;
            rden_d      = 1'b1;
            rdaddress_d = base_new;
          end
        end
      end

      ISSUE: begin
        state_d = WAITQ;
        lat_d   = 2'd1;
      end

      // lat_cnt counts cycles since the read was issued; data is valid when
      // it reaches the RAM latency.
      WAITQ: begin
        if (lat_cnt == 2'(RAM_LAT)) begin
          out_data_d  = ram_q[{ch, 3'b000} +: 8];
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          lat_d = lat_cnt + 2'd1;
        end
      end

      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_inc[RAM_WIDTH-1:0];
          addr_d      = addr_inc;
          if (cnt_inc < {1'b0, nsmp_q}) begin
            state_d     = ISSUE;
            rden_d      = 1'b1;
            rdaddress_d = addr_inc;
          end else if (wk_more) begin
            wk_adv      = 1'b1;
            addr_d      = base;
            cnt_d       = '0;
            state_d     = ISSUE;
            rden_d      = 1'b1;
            rdaddress_d = base;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      pending   <= 1'b0;
      busy      <= 1'b0;
      rden      <= 1'b0;
      rdaddress <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      base      <= '0;
      addr      <= '0;
      cnt       <= '0;
      nsmp_q    <= '0;
      lat_cnt   <= '0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      busy      <= busy_d;
      rden      <= rden_d;
      rdaddress <= rdaddress_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      done      <= done_d;
      base      <= base_d;
      addr      <= addr_d;
      cnt       <= cnt_d;
      nsmp_q    <= nsmp_d;
      lat_cnt   <= lat_d;
    end
  end

endmodule
